// File: rtl/pad_in_rx.sv
// Pad input return path: synchronize, glitch-filter, mask driven pads,
// detect edges and keep sticky event flags with an aggregated interrupt.
module pad_in_rx #(
    parameter int NumPads = 72,
    parameter int CntW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumPads-1:0] outi_i,
    input  logic [NumPads-1:0] oe_i,
    input  logic [NumPads-1:0] filt_en_i,
    input  logic [CntW-1:0]    filt_thresh_i,
    input  logic [NumPads-1:0] evt_rise_en_i,
    input  logic [NumPads-1:0] evt_fall_en_i,
    input  logic [NumPads-1:0] evt_clr_i,
    output logic [NumPads-1:0] in_sync_o,
    output logic [NumPads-1:0] in_filt_o,
    output logic [NumPads-1:0] rise_o,
    output logic [NumPads-1:0] fall_o,
    output logic [NumPads-1:0] evt_o,
    output logic               irq_o
);

    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

    logic [NumPads-1:0] sync1_q, sync1_d;
    logic [NumPads-1:0] sync2_q, sync2_d;
    logic [NumPads-1:0] filt_q, filt_d;
    logic [NumPads-1:0] rise_q, rise_d;
    logic [NumPads-1:0] fall_q, fall_d;
    logic [NumPads-1:0] evt_q, evt_d;
    logic [CntW-1:0]    cnt_q [NumPads];
    logic [CntW-1:0]    cnt_d [NumPads];
    logic               irq_q, irq_d;

    always_comb begin
        sync1_d = outi_i;
        sync2_d = sync1_q;
    end

    // A change is accepted only after T+1 consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NumPads; i++) begin
            cnt_d[i] = '0;
            if (!oe_i[i]) begin
                if (!filt_en_i[i]) begin
                    filt_d[i] = sync2_q[i];
                end else if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == filt_thresh_i) begin
                        filt_d[i] = sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
            end
        end
    end

    always_comb begin
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
        evt_d  = (evt_q & ~evt_clr_i)
               | (rise_q & evt_rise_en_i)
               | (fall_q & evt_fall_en_i);
        irq_d  = |evt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NumPads; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NumPads; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_sync_o = sync2_q;
    assign in_filt_o = filt_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign evt_o     = evt_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_pad_in_rx.sv
// Directed and random checks of pad_in_rx against a sample-history
// reference model of sync delay, glitch filter, edges and sticky events.
module tb_pad_in_rx;

    localparam int N = 72;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] outi = '0, oe = '0, fen = '0;
    logic [N-1:0] ren = '0, fln = '0, clr = '0;
    logic [W-1:0] thr = '0;
    logic [N-1:0] in_sync_o, in_filt_o, rise_o, fall_o, evt_o;
    logic         irq_o;

    int errs = 0;
    int checks = 0;

    logic [N-1:0] m_s1, m_s2, m_filt, m_rise, m_fall, m_evt;
    logic         m_irq;
    int           m_run [N];

    pad_in_rx #(.NumPads(N), .CntW(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .outi_i(outi), .oe_i(oe),
        .filt_en_i(fen), .filt_thresh_i(thr),
        .evt_rise_en_i(ren), .evt_fall_en_i(fln), .evt_clr_i(clr),
        .in_sync_o(in_sync_o), .in_filt_o(in_filt_o),
        .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_filt = '0;
        m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // Filtered value flips once the sampled input has disagreed with it
    // for T+1 samples in a row; edges are where the filtered value moves.
    task automatic model_step();
        logic [N-1:0] nf;
        int t;
        if (rst_i) begin
            model_clear();
            return;
        end
        t = int'(thr);
        nf = m_filt;
        for (int i = 0; i < N; i++) begin
            if (oe[i]) begin
                m_run[i] = 0;
            end else if (!fen[i]) begin
                nf[i] = m_s2[i];
                m_run[i] = 0;
            end else if (m_s2[i] == m_filt[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == t + 1) begin
                    nf[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_irq  = (m_evt != '0);
        m_evt  = (m_evt & ~clr) | (m_rise & ren) | (m_fall & fln);
        m_rise = nf & ~m_filt;
        m_fall = ~nf & m_filt;
        m_filt = nf;
        m_s2   = m_s1;
        m_s1   = outi;
    endtask

    task automatic check_all();
        chk("in_sync", in_sync_o, m_s2);
        chk("in_filt", in_filt_o, m_filt);
        chk("rise", rise_o, m_rise);
        chk("fall", fall_o, m_fall);
        chk("evt", evt_o, m_evt);
        chk1("irq", irq_o, m_irq);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    function automatic logic [N-1:0] rand72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[N-1:0];
    endfunction

    initial begin
        model_clear();

        for (int k = 0; k < 4; k++) begin
            outi = rand72();
            tick();
        end
        chk("rst_sync", in_sync_o, '0);
        chk("rst_filt", in_filt_o, '0);
        chk("rst_evt", evt_o, '0);
        chk1("rst_irq", irq_o, 1'b0);

        outi = '0;
        rst_i = 1'b0;
        outi[0] = 1'b1;
        tick();
        chk1("lat_sync_e1", in_sync_o[0], 1'b0);
        tick();
        chk1("lat_sync_e2", in_sync_o[0], 1'b1);
        chk1("lat_filt_e2", in_filt_o[0], 1'b0);
        tick();
        chk1("lat_filt_e3", in_filt_o[0], 1'b1);
        chk1("lat_rise_e3", rise_o[0], 1'b1);
        tick();
        chk1("lat_rise_e4", rise_o[0], 1'b0);

        thr = 4'd3;
        fen[5] = 1'b1;
        outi[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) outi[5] = 1'b0;
            tick();
            chk1("glitch_filt", in_filt_o[5], 1'b0);
            chk1("glitch_rise", rise_o[5], 1'b0);
        end
        for (int k = 1; k <= 12; k++) begin
            outi[5] = (k <= 4);
            tick();
            chk1("pulse_filt", in_filt_o[5], (k >= 6 && k < 10));
            chk1("pulse_rise", rise_o[5], (k == 6));
            chk1("pulse_fall", fall_o[5], (k == 10));
        end

        oe[10] = 1'b1;
        ren[10] = 1'b1;
        fln[10] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            outi[10] = ~outi[10];
            tick();
            chk1("mask_filt", in_filt_o[10], 1'b0);
            chk1("mask_rise", rise_o[10], 1'b0);
            chk1("mask_fall", fall_o[10], 1'b0);
            chk1("mask_evt", evt_o[10], 1'b0);
        end
        outi[10] = 1'b1;
        repeat (3) tick();
        chk1("mask_sync", in_sync_o[10], 1'b1);
        oe[10] = 1'b0;
        tick();
        chk1("unmask_rise", rise_o[10], 1'b1);
        tick();
        chk1("unmask_evt", evt_o[10], 1'b1);
        ren[10] = 1'b0;
        fln[10] = 1'b0;
        clr[10] = 1'b1;
        tick();
        chk1("unmask_clr", evt_o[10], 1'b0);
        clr[10] = 1'b0;
        repeat (2) tick();
        chk1("irq_idle", irq_o, 1'b0);

        ren[2] = 1'b1;
        outi[2] = 1'b1;
        repeat (3) tick();
        chk1("ev_rise", rise_o[2], 1'b1);
        tick();
        chk1("ev_set", evt_o[2], 1'b1);
        chk1("ev_irq_lag", irq_o, 1'b0);
        tick();
        chk1("ev_irq", irq_o, 1'b1);
        outi[2] = 1'b0;
        repeat (6) tick();
        chk1("ev_no_fall_clr", evt_o[2], 1'b1);
        clr[2] = 1'b1;
        tick();
        chk1("ev_clr", evt_o[2], 1'b0);
        chk1("ev_irq_hold", irq_o, 1'b1);
        clr[2] = 1'b0;
        tick();
        chk1("ev_irq_drop", irq_o, 1'b0);
        ren[2] = 1'b0;

        ren[7] = 1'b1;
        outi[7] = 1'b1;
        repeat (3) tick();
        chk1("col_rise", rise_o[7], 1'b1);
        clr[7] = 1'b1;
        tick();
        chk1("col_set_wins", evt_o[7], 1'b1);
        clr[7] = 1'b0;
        tick();
        chk1("col_sticky", evt_o[7], 1'b1);
        ren[7] = 1'b0;
        clr[7] = 1'b1;
        tick();
        clr[7] = 1'b0;
        repeat (2) tick();

        fen = '0;
        tick();
        thr = 4'd15;
        fen[3] = 1'b1;
        outi[3] = 1'b1;
        repeat (10) begin
            tick();
            chk1("mid_filt", in_filt_o[3], 1'b0);
        end
        rst_i = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("mid_rst_sync", in_sync_o, '0);
        tick();
        rst_i = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk1("mid_restart", in_filt_o[3], (k == 18));
        end

        for (int p = 0; p < 8; p++) begin
            fen = '0;
            tick();
            thr = W'($urandom_range(0, 6));
            fen = rand72();
            oe  = rand72() & rand72() & rand72();
            ren = rand72();
            fln = rand72();
            for (int k = 0; k < 200; k++) begin
                outi = outi ^ (rand72() & rand72() & rand72());
                clr  = rand72() & rand72() & rand72() & rand72();
                if ($urandom_range(0, 15) == 0) oe = oe ^ (rand72() & rand72());
                tick();
            end
            clr = '0;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
